// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and helpers for the multi-cycle core sequencer.
// State encoding is fixed so the exported state port stays stable for debug tools.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } ctrl_state_t;

    localparam int DEFAULT_TIMEOUT = 256;
    localparam int DEFAULT_CNT_W   = 64;

    // States that park on an external done handshake and are watched by the timer
    function automatic logic is_wait_state(input ctrl_state_t s);
        return (s == FETCH) || (s == EXEC) || (s == MEM);
    endfunction

    function automatic logic is_busy_state(input ctrl_state_t s);
        return !((s == IDLE) || (s == HALT) || (s == ERR));
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake and strobe bundle between the sequencer (master) and the datapath/buses (slave).
interface multicycle_ctrl_if;

    logic ibus_valid;
    logic ibus_data_ok;
    logic idu_valid;
    logic exu_valid;
    logic exu_done;
    logic dbus_valid;
    logic dbus_data_ok;
    logic dec_mem_rd;
    logic dec_mem_wr;
    logic dec_rf_w;
    logic dec_skip;
    logic rf_we;
    logic pc_we;

    modport master (
        output ibus_valid, idu_valid, exu_valid, dbus_valid, rf_we, pc_we,
        input  ibus_data_ok, exu_done, dbus_data_ok,
        input  dec_mem_rd, dec_mem_wr, dec_rf_w, dec_skip
    );

    modport slave (
        input  ibus_valid, idu_valid, exu_valid, dbus_valid, rf_we, pc_we,
        output ibus_data_ok, exu_done, dbus_data_ok,
        output dec_mem_rd, dec_mem_wr, dec_rf_w, dec_skip
    );

endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Watchdog for handshake stages: counts cycles spent waiting on done and flags
// the last allowed cycle so the sequencer can divert to ERR instead of hanging.
module ctrl_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic done,
    output logic expired
);

    localparam int            W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic          ENABLED = (TIMEOUT != 0);
    localparam logic [W-1:0]  LAST    = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] cnt;

    // Saturate at LAST so a disabled watchdog never wraps into a false compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en || done) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = ENABLED && en && !done && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Central sequencer for the multi-cycle RV64 core: FETCH/DECODE/EXEC/[MEM]/WB with
// registered Moore strobes, handshake watchdog, and cycle/retired-instruction counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt_req,
    multicycle_ctrl_if.master   bus,
    output logic                busy,
    output logic                bus_err,
    output ctrl_state_t         state,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instret
);

    ctrl_state_t state_n;
    logic        stage_done;
    logic        in_wait;
    logic        wd_expired;
    logic        state_change;

    // Only the done strobe belonging to the current stage counts; stray ones are ignored
    always_comb begin
        stage_done = 1'b0;
        case (state)
            FETCH:   stage_done = bus.ibus_data_ok;
            EXEC:    stage_done = bus.exu_done;
            MEM:     stage_done = bus.dbus_data_ok;
            default: stage_done = 1'b0;
        endcase
    end

    assign in_wait      = is_wait_state(state);
    assign state_change = (state_n != state);

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_change),
        .en      (in_wait),
        .done    (stage_done),
        .expired (wd_expired)
    );

    // A done arriving on the expiry cycle still wins over the watchdog
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = halt_req ? HALT : FETCH;
            FETCH:   if (stage_done)      state_n = DECODE;
                     else if (wd_expired) state_n = ERR;
            DECODE:  state_n = EXEC;
            EXEC:    if (stage_done)      state_n = (bus.dec_mem_rd || bus.dec_mem_wr) ? MEM : WB;
                     else if (wd_expired) state_n = ERR;
            MEM:     if (stage_done)      state_n = WB;
                     else if (wd_expired) state_n = ERR;
            WB:      state_n = halt_req ? HALT : FETCH;
            HALT:    state_n = halt_req ? HALT : FETCH;
            ERR:     state_n = ERR;
            default: state_n = ERR;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.ibus_valid <= 1'b0;
            bus.idu_valid  <= 1'b0;
            bus.exu_valid  <= 1'b0;
            bus.dbus_valid <= 1'b0;
            bus.pc_we      <= 1'b0;
            bus.rf_we      <= 1'b0;
            busy           <= 1'b0;
            bus_err        <= 1'b0;
            cycle_cnt      <= '0;
            instret        <= '0;
        end else begin
            state          <= state_n;
            bus.ibus_valid <= (state_n == FETCH);
            bus.idu_valid  <= (state_n == DECODE);
            bus.exu_valid  <= (state_n == EXEC);
            bus.dbus_valid <= (state_n == MEM);
            bus.pc_we      <= (state_n == WB);
            bus.rf_we      <= (state_n == WB) && bus.dec_rf_w && !bus.dec_skip;
            busy           <= is_busy_state(state_n);
            bus_err        <= (state_n == ERR);
            cycle_cnt      <= cycle_cnt + CNT_W'(busy);
            instret        <= instret + CNT_W'(state == WB);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into an expected
// per-cycle stage timeline from its wait counts, then played against the DUT.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int TO = 4;
    localparam int CW = 16;

    typedef struct {
        ctrl_state_t st;
        logic        ok_i;
        logic        ok_d;
        logic        done_e;
        logic        halt;
    } cyc_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              halt_req = 1'b0;
    logic              busy;
    logic              bus_err;
    ctrl_state_t       state;
    logic [CW-1:0]     cycle_cnt;
    logic [CW-1:0]     instret;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halt_req  (halt_req),
        .bus       (bus),
        .busy      (busy),
        .bus_err   (bus_err),
        .state     (state),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    cyc_t        plan[$];
    logic [CW-1:0] m_cyc;
    logic [CW-1:0] m_inst;
    ctrl_state_t prev_st;
    logic        cur_rd, cur_wr, cur_rfw, cur_skip, exp_rf;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic counts_busy(input ctrl_state_t s);
        return (s != IDLE) && (s != HALT) && (s != ERR);
    endfunction

    // Expected {ibus_valid, idu_valid, exu_valid, dbus_valid, pc_we, rf_we} for a stage
    function automatic logic [5:0] strobes_for(input ctrl_state_t s, input logic rfw);
        return {s == FETCH, s == DECODE, s == EXEC, s == MEM, s == WB, (s == WB) && rfw};
    endfunction

    task automatic check_cycle(input ctrl_state_t exp_st);
        if (counts_busy(prev_st)) m_cyc = m_cyc + 1'b1;
        if (prev_st == WB)        m_inst = m_inst + 1'b1;
        check_output("state", 64'(state), 64'(exp_st));
        check_output("strobes",
                     64'({bus.ibus_valid, bus.idu_valid, bus.exu_valid, bus.dbus_valid, bus.pc_we, bus.rf_we}),
                     64'(strobes_for(exp_st, exp_rf)));
        check_output("busy", 64'(busy), 64'(counts_busy(exp_st)));
        check_output("bus_err", 64'(bus_err), 64'(exp_st == ERR));
        check_output("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
        check_output("instret", 64'(instret), 64'(m_inst));
        prev_st = exp_st;
    endtask

    task automatic check_reset_state();
        check_output("rst_state", 64'(state), 64'(IDLE));
        check_output("rst_strobes",
                     64'({bus.ibus_valid, bus.idu_valid, bus.exu_valid, bus.dbus_valid, bus.pc_we, bus.rf_we}), 64'd0);
        check_output("rst_flags", 64'({busy, bus_err}), 64'd0);
        check_output("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check_output("rst_instret", 64'(instret), 64'd0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        m_cyc   = '0;
        m_inst  = '0;
        prev_st = IDLE;
        @(negedge clk);
        rst = 1'b0;
        halt_req = 1'b0;
        bus.ibus_data_ok = rnd();
        bus.exu_done     = rnd();
        bus.dbus_data_ok = rnd();
    endtask

    task automatic push_entry(input ctrl_state_t st, input logic oi, input logic de, input logic od, input logic h);
        cyc_t c;
        c.st = st; c.ok_i = oi; c.done_e = de; c.ok_d = od; c.halt = h;
        plan.push_back(c);
    endtask

    // A stage waiting w cycles for done; at or beyond TO it never sees done and ends in ERR
    task automatic add_wait(input ctrl_state_t st, input int w, output bit timed_out);
        int n;
        n = (w >= TO) ? TO : w + 1;
        for (int k = 0; k < n; k++) begin
            push_entry(st,
                       (st == FETCH) ? (k == w) : rnd(),
                       (st == EXEC)  ? (k == w) : rnd(),
                       (st == MEM)   ? (k == w) : rnd(),
                       rnd());
        end
        timed_out = (w >= TO);
        if (timed_out) begin
            for (int k = 0; k < 3; k++) push_entry(ERR, rnd(), rnd(), rnd(), rnd());
        end
    endtask

    task automatic plan_instr(input int wf, input int we, input int wm,
                              input logic rd, input logic wr, input logic rfw, input logic skip,
                              input int halt_cycles, input bit abort, output bit err);
        bit to;
        err = 1'b0;
        cur_rd = rd; cur_wr = wr; cur_rfw = rfw; cur_skip = skip;
        exp_rf = rfw & ~skip;
        add_wait(FETCH, wf, to);
        if (to) begin err = 1'b1; return; end
        push_entry(DECODE, rnd(), rnd(), rnd(), rnd());
        if (abort) begin
            push_entry(EXEC, rnd(), 1'b0, rnd(), rnd());
            return;
        end
        add_wait(EXEC, we, to);
        if (to) begin err = 1'b1; return; end
        if (rd || wr) begin
            add_wait(MEM, wm, to);
            if (to) begin err = 1'b1; return; end
        end
        push_entry(WB, rnd(), rnd(), rnd(), halt_cycles > 0);
        for (int k = 0; k < halt_cycles; k++)
            push_entry(HALT, rnd(), rnd(), rnd(), k < halt_cycles - 1);
    endtask

    task automatic apply_stimulus();
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(posedge clk);
            #1;
            check_cycle(c.st);
            if (c.st == FETCH) begin
                bus.dec_mem_rd = rnd(); bus.dec_mem_wr = rnd();
                bus.dec_rf_w   = rnd(); bus.dec_skip   = rnd();
            end else if (c.st == DECODE) begin
                bus.dec_mem_rd = cur_rd; bus.dec_mem_wr = cur_wr;
                bus.dec_rf_w   = cur_rfw; bus.dec_skip  = cur_skip;
            end
            bus.ibus_data_ok = c.ok_i;
            bus.exu_done     = c.done_e;
            bus.dbus_data_ok = c.ok_d;
            halt_req         = c.halt;
        end
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        bit err;
        bus.ibus_data_ok = 1'b0; bus.exu_done = 1'b0; bus.dbus_data_ok = 1'b0;
        bus.dec_mem_rd = 1'b0; bus.dec_mem_wr = 1'b0; bus.dec_rf_w = 1'b0; bus.dec_skip = 1'b0;
        exp_rf = 1'b0;
        m_cyc = '0; m_inst = '0; prev_st = IDLE;
        #3;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] abort mid-EXEC with reset");
        plan_instr(0, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, err);
        apply_stimulus();
        do_reset();

        $display("[TB] directed ALU, load, store, skip");
        plan_instr(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, err); apply_stimulus();
        plan_instr(0, 0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, err); apply_stimulus();
        plan_instr(1, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, err); apply_stimulus();
        plan_instr(0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, err); apply_stimulus();

        $display("[TB] watchdog expiry and last-cycle done");
        plan_instr(TO, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, err); apply_stimulus();
        do_reset();
        plan_instr(TO - 1, TO - 1, TO - 1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, err); apply_stimulus();
        plan_instr(0, 0, TO, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, err); apply_stimulus();
        do_reset();

        $display("[TB] halt after completion and halt from IDLE");
        plan_instr(0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0, err); apply_stimulus();
        do_reset();
        halt_req = 1'b1;
        push_entry(HALT, rnd(), rnd(), rnd(), 1'b1);
        push_entry(HALT, rnd(), rnd(), rnd(), 1'b0);
        apply_stimulus();

        $display("[TB] randomized instruction stream");
        for (int i = 0; i < 200; i++) begin
            plan_instr(rand_wait(), rand_wait(), rand_wait(), rnd(), rnd(), rnd(), rnd(),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0, err);
            apply_stimulus();
            if (err) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "[TB] global timeout");
    end

endmodule
